// File: rtl/datapath_executor_pkg.sv
// Shared constants for the datapath executor: opcodes, instruction field positions,
// pixel/memory widths and the executor FSM state type.
package datapath_executor_pkg;

   localparam int INSTRUCTION_WIDTH      = 32;
   localparam int DEFAULT_MEM_ADDR_WIDTH = 16;
   localparam int DEFAULT_RESULT_WIDTH   = 16;

   localparam int X_WIDTH      = 8;
   localparam int Y_WIDTH      = 7;
   localparam int COLOUR_WIDTH = 3;

   localparam int DEFAULT_SCREEN_WIDTH  = 160;
   localparam int DEFAULT_SCREEN_HEIGHT = 120;
   localparam int DEFAULT_BLOCK_WIDTH   = 4;
   localparam int DEFAULT_BLOCK_HEIGHT  = 4;

   localparam logic [3:0] OPCODE_NOP      = 4'd0;
   localparam logic [3:0] OPCODE_MEMREAD  = 4'd1;
   localparam logic [3:0] OPCODE_MEMWRITE = 4'd2;
   localparam logic [3:0] OPCODE_DRAW     = 4'd3;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int DATA_MSB   = 27;
   localparam int DATA_LSB   = 16;
   localparam int PLOT_BIT   = 18;
   localparam int COLOUR_MSB = 17;
   localparam int COLOUR_LSB = 15;
   localparam int Y_MSB      = 14;
   localparam int Y_LSB      = 8;
   localparam int X_MSB      = 7;
   localparam int X_LSB      = 0;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_WAIT,
      RD_CAPTURE,
      WR,
      DRAW,
      DONE
   } state_t;

   // Counter width for a dimension; a dimension of 1 still needs one bit.
   function automatic int count_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/datapath_executor_block_scanner.sv
// Walks the BLOCK_WIDTH x BLOCK_HEIGHT offsets of one DRAW, x fastest, and flags
// which pixels land on screen and which offset is the final one.
module datapath_executor_block_scanner
   import datapath_executor_pkg::*;
#(
   parameter int BLOCK_WIDTH   = DEFAULT_BLOCK_WIDTH,
   parameter int BLOCK_HEIGHT  = DEFAULT_BLOCK_HEIGHT,
   parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
   parameter int DX_WIDTH      = count_width(BLOCK_WIDTH),
   parameter int DY_WIDTH      = count_width(BLOCK_HEIGHT)
)(
   input  logic                clock,
   input  logic                resetn,
   input  logic                start,
   input  logic [X_WIDTH-1:0]  base_x,
   input  logic [Y_WIDTH-1:0]  base_y,
   output logic [DX_WIDTH-1:0] dx,
   output logic [DY_WIDTH-1:0] dy,
   output logic                pixel_valid,
   output logic                last
);

   localparam int SUM_X_WIDTH = X_WIDTH + 1;
   localparam int SUM_Y_WIDTH = Y_WIDTH + 1;
   localparam logic [DX_WIDTH-1:0] DX_LAST = DX_WIDTH'(BLOCK_WIDTH - 1);
   localparam logic [DY_WIDTH-1:0] DY_LAST = DY_WIDTH'(BLOCK_HEIGHT - 1);

   logic [DX_WIDTH-1:0]    dx_reg, dx_next;
   logic [DY_WIDTH-1:0]    dy_reg, dy_next;
   logic                   active_reg, active_next;
   logic [SUM_X_WIDTH-1:0] sum_x;
   logic [SUM_Y_WIDTH-1:0] sum_y;

   // One extra bit keeps x+dx from wrapping back onto the left edge.
   assign sum_x = {1'b0, base_x} + SUM_X_WIDTH'(dx_reg);
   assign sum_y = {1'b0, base_y} + SUM_Y_WIDTH'(dy_reg);

   assign dx          = dx_reg;
   assign dy          = dy_reg;
   assign pixel_valid = active_reg && (sum_x < SUM_X_WIDTH'(SCREEN_WIDTH))
                                   && (sum_y < SUM_Y_WIDTH'(SCREEN_HEIGHT));
   assign last        = active_reg && (dx_reg == DX_LAST) && (dy_reg == DY_LAST);

   always_comb begin
      dx_next     = dx_reg;
      dy_next     = dy_reg;
      active_next = active_reg;
      if (start) begin
         dx_next     = '0;
         dy_next     = '0;
         active_next = 1'b1;
      end else if (active_reg) begin
         if (dx_reg == DX_LAST) begin
            dx_next = '0;
            if (dy_reg == DY_LAST) begin
               dy_next     = '0;
               active_next = 1'b0;
            end else begin
               dy_next = dy_reg + DY_WIDTH'(1);
            end
         end else begin
            dx_next = dx_reg + DX_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         dx_reg     <= '0;
         dy_reg     <= '0;
         active_reg <= 1'b0;
      end else begin
         dx_reg     <= dx_next;
         dy_reg     <= dy_next;
         active_reg <= active_next;
      end
   end

endmodule

// File: rtl/datapath_executor.sv
// Responder side of the controller instruction handshake: decodes one instruction per
// start rising edge and runs it against the state RAM or the VGA pixel port.
module datapath_executor
   import datapath_executor_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH,
   parameter int RESULT_WIDTH   = DEFAULT_RESULT_WIDTH,
   parameter int BLOCK_WIDTH    = DEFAULT_BLOCK_WIDTH,
   parameter int BLOCK_HEIGHT   = DEFAULT_BLOCK_HEIGHT,
   parameter int SCREEN_WIDTH   = DEFAULT_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT  = DEFAULT_SCREEN_HEIGHT
)(
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         finished,
   output logic [RESULT_WIDTH-1:0]      result,
   output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
   output logic [RESULT_WIDTH-1:0]      mem_data,
   output logic                         mem_wren,
   input  logic [RESULT_WIDTH-1:0]      mem_q,
   output logic [X_WIDTH-1:0]           vga_x,
   output logic [Y_WIDTH-1:0]           vga_y,
   output logic [COLOUR_WIDTH-1:0]      vga_colour,
   output logic                         vga_plot
);

   localparam int DX_WIDTH = count_width(BLOCK_WIDTH);
   localparam int DY_WIDTH = count_width(BLOCK_HEIGHT);

   state_t                    state_reg, state_next;
   logic                      start_q_reg;
   logic                      finished_reg, finished_next;
   logic [RESULT_WIDTH-1:0]   result_reg, result_next;
   logic [MEM_ADDR_WIDTH-1:0] mem_address_reg, mem_address_next;
   logic [RESULT_WIDTH-1:0]   mem_data_reg, mem_data_next;
   logic                      mem_wren_reg, mem_wren_next;
   logic [X_WIDTH-1:0]        vga_x_reg, vga_x_next;
   logic [Y_WIDTH-1:0]        vga_y_reg, vga_y_next;
   logic [COLOUR_WIDTH-1:0]   vga_colour_reg, vga_colour_next;
   logic                      vga_plot_reg, vga_plot_next;
   logic [X_WIDTH-1:0]        draw_x_reg, draw_x_next;
   logic [Y_WIDTH-1:0]        draw_y_reg, draw_y_next;
   logic [COLOUR_WIDTH-1:0]   draw_colour_reg, draw_colour_next;
   logic                      draw_plot_reg, draw_plot_next;

   logic [3:0]          opcode;
   logic                accept;
   logic                scan_start;
   logic [DX_WIDTH-1:0] dx;
   logic [DY_WIDTH-1:0] dy;
   logic                pixel_valid;
   logic                scan_last;

   assign opcode = instruction[OPCODE_MSB:OPCODE_LSB];
   // Only a rising edge of start in IDLE counts, so a held request is taken once.
   assign accept = (state_reg == IDLE) && start && !start_q_reg;

   datapath_executor_block_scanner #(
      .BLOCK_WIDTH   (BLOCK_WIDTH),
      .BLOCK_HEIGHT  (BLOCK_HEIGHT),
      .SCREEN_WIDTH  (SCREEN_WIDTH),
      .SCREEN_HEIGHT (SCREEN_HEIGHT),
      .DX_WIDTH      (DX_WIDTH),
      .DY_WIDTH      (DY_WIDTH)
   ) u_block_scanner (
      .clock       (clock),
      .resetn      (resetn),
      .start       (scan_start),
      .base_x      (draw_x_reg),
      .base_y      (draw_y_reg),
      .dx          (dx),
      .dy          (dy),
      .pixel_valid (pixel_valid),
      .last        (scan_last)
   );

   always_comb begin
      state_next       = state_reg;
      finished_next    = finished_reg;
      result_next      = result_reg;
      mem_address_next = mem_address_reg;
      mem_data_next    = mem_data_reg;
      mem_wren_next    = mem_wren_reg;
      vga_x_next       = vga_x_reg;
      vga_y_next       = vga_y_reg;
      vga_colour_next  = vga_colour_reg;
      vga_plot_next    = vga_plot_reg;
      draw_x_next      = draw_x_reg;
      draw_y_next      = draw_y_reg;
      draw_colour_next = draw_colour_reg;
      draw_plot_next   = draw_plot_reg;
      scan_start       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               finished_next    = 1'b0;
               result_next      = '0;
               draw_x_next      = instruction[X_MSB:X_LSB];
               draw_y_next      = instruction[Y_MSB:Y_LSB];
               draw_colour_next = instruction[COLOUR_MSB:COLOUR_LSB];
               draw_plot_next   = instruction[PLOT_BIT];
               case (opcode)
                  OPCODE_MEMREAD: begin
                     mem_address_next = instruction[MEM_ADDR_WIDTH-1:0];
                     state_next       = RD_WAIT;
                  end
                  OPCODE_MEMWRITE: begin
                     mem_address_next = instruction[MEM_ADDR_WIDTH-1:0];
                     mem_data_next    = RESULT_WIDTH'(instruction[DATA_MSB:DATA_LSB]);
                     mem_wren_next    = 1'b1;
                     state_next       = WR;
                  end
                  OPCODE_DRAW: begin
                     scan_start = 1'b1;
                     state_next = DRAW;
                  end
                  OPCODE_NOP: state_next = DONE;
                  default:    state_next = DONE;
               endcase
            end
         end
         RD_ADDR: state_next = RD_WAIT;
         RD_WAIT: state_next = RD_CAPTURE;
         RD_CAPTURE: begin
            result_next   = mem_q;
            finished_next = 1'b1;
            state_next    = IDLE;
         end
         WR: begin
            mem_wren_next = 1'b0;
            finished_next = 1'b1;
            state_next    = IDLE;
         end
         DRAW: begin
            vga_x_next      = draw_x_reg + X_WIDTH'(dx);
            vga_y_next      = draw_y_reg + Y_WIDTH'(dy);
            vga_colour_next = draw_colour_reg;
            vga_plot_next   = draw_plot_reg && pixel_valid;
            if (scan_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            vga_plot_next = 1'b0;
            finished_next = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_reg       <= IDLE;
         start_q_reg     <= 1'b0;
         finished_reg    <= 1'b1;
         result_reg      <= '0;
         mem_address_reg <= '0;
         mem_data_reg    <= '0;
         mem_wren_reg    <= 1'b0;
         vga_x_reg       <= '0;
         vga_y_reg       <= '0;
         vga_colour_reg  <= '0;
         vga_plot_reg    <= 1'b0;
         draw_x_reg      <= '0;
         draw_y_reg      <= '0;
         draw_colour_reg <= '0;
         draw_plot_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         start_q_reg     <= start;
         finished_reg    <= finished_next;
         result_reg      <= result_next;
         mem_address_reg <= mem_address_next;
         mem_data_reg    <= mem_data_next;
         mem_wren_reg    <= mem_wren_next;
         vga_x_reg       <= vga_x_next;
         vga_y_reg       <= vga_y_next;
         vga_colour_reg  <= vga_colour_next;
         vga_plot_reg    <= vga_plot_next;
         draw_x_reg      <= draw_x_next;
         draw_y_reg      <= draw_y_next;
         draw_colour_reg <= draw_colour_next;
         draw_plot_reg   <= draw_plot_next;
      end
   end

   assign finished    = finished_reg;
   assign result      = result_reg;
   assign mem_address = mem_address_reg;
   assign mem_data    = mem_data_reg;
   assign mem_wren    = mem_wren_reg;
   assign vga_x       = vga_x_reg;
   assign vga_y       = vga_y_reg;
   assign vga_colour  = vga_colour_reg;
   assign vga_plot    = vga_plot_reg;

endmodule

// File: doc/datapath_executor.md
Name: datapath_executor

Overview:
- Responder end of the instruction handshake used by the ant draw/update controllers.
- Accepts one 32-bit instruction per start pulse and decodes it as MEMREAD, MEMWRITE, DRAW or NOP.
- Executes it against the shared synchronous state RAM or the VGA adapter pixel port, then raises finished with the result held valid.
- Sits between the controller arbiter and RAM/VGA.

Parameters:
- MEM_ADDR_WIDTH, 16, RAM word address width; instruction bits [15:0].
- RESULT_WIDTH, 16, RAM data width and result width.
- BLOCK_WIDTH, 4, pixels drawn per DRAW in x.
- BLOCK_HEIGHT, 4, pixels drawn per DRAW in y.
- SCREEN_WIDTH, 160, x clip limit (exclusive).
- SCREEN_HEIGHT, 120, y clip limit (exclusive).

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request from initiator; acted on only at its rising edge.
- instruction  in  32  [31:28] opcode; remaining fields per opcode.
- finished  out  1  1 = idle/result valid; 0 = busy.
- result  out  RESULT_WIDTH  read data (MEMREAD), else 0.
- mem_address  out  MEM_ADDR_WIDTH  RAM address.
- mem_data  out  RESULT_WIDTH  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  RESULT_WIDTH  RAM read data; valid 2 cycles after address is driven.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write strobe.

Behaviour:
- Reset: state IDLE, finished=1, result=0, mem_address=0, mem_data=0, mem_wren=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, start_q=0. Reset mid-operation aborts immediately; no further write or plot.
- Accept: at an edge in IDLE with start=1 and start_q=0 (start_q is start registered each cycle):
  - latch instruction;
  - finished<=0;
  - result<=0.
- A start held high (initiators hold it for 2 cycles) is never re-accepted. start is ignored outside IDLE.
- States:
  - IDLE
  - RD_ADDR
  - RD_WAIT
  - RD_CAPTURE
  - WR
  - DRAW
  - DONE
- Accept edge = A. In every case finished is 0 from A until completion.
- MEMREAD (opcode 4'd1, addr [15:0]):
  - A: mem_address<=addr, go RD_WAIT.
  - A+1: go RD_CAPTURE.
  - A+2: result<=mem_q, finished<=1, go IDLE.
- MEMWRITE (4'd2, data [27:16] zero-extended to 16 bits, addr [15:0]):
  - A: mem_address<=addr, mem_data<=data, mem_wren<=1, go WR.
  - A+1: mem_wren<=0, finished<=1, go IDLE.
  - mem_wren is high for exactly one cycle.
- DRAW (4'd3, plot bit [18], colour [17:15], y [14:8], x [7:0]):
  - Scan BLOCK_WIDTH*BLOCK_HEIGHT pixels, x-offset fastest. Offsets use a 2-bit dx and a 2-bit dy counter, sized from the BLOCK dimensions.
  - Each DRAW cycle drives vga_x=x+dx, vga_y=y+dy, vga_colour=colour.
  - vga_plot=plot AND (x+dx<SCREEN_WIDTH) AND (y+dy<SCREEN_HEIGHT). Compute sums one bit wider before comparing, so no wrap.
  - Last pixel at edge A+16; finished<=1 at edge A+17 with vga_plot<=0.
- NOP and undefined opcodes: finished<=1 at A+1, result=0, no side effects.
- result and finished are held stable in IDLE until the next accept.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared constants header (existing constants.h): OPCODE_MEMREAD/MEMWRITE/DRAW/NOP, INSTRUCTION_WIDTH=32, MEM_ADDR_WIDTH, RESULT_WIDTH, X/Y/COLOUR widths, SCREEN and BLOCK dimensions, and field bit positions.
- One sub-module is natural: block_scanner. It takes start/base x/y, outputs dx/dy, a pixel-valid signal and a last flag, and is instantiated for DRAW.

Test Plan:
- MEMWRITE then MEMREAD: instruction 0x2_00A_0040 → mem_wren=1 for one cycle with address 0x0040 and data 0x000A, then finished=1. Next, 0x1_000_0040 → result=0x000A at A+2, finished=1.
- Held start: start high 2 cycles with MEMWRITE → exactly one accept and one mem_wren pulse. finished is 0 at the initiator's first wait sample, edge A+1.
- DRAW interior: x=10, y=20, colour=3'b100, plot=1 → 16 plots covering (10..13, 20..23) in x-fastest order; finished at A+17.
- DRAW clipped: x=158, y=118 → 4 plots (158..159, 118..119), 12 cycles with vga_plot=0. Same total latency; no wrap to x=0.
- DRAW with plot=0 → no vga_plot assertion; finished still at A+17.
- Reset at A+5 during DRAW → vga_plot=0 and finished=1 next cycle. A subsequent MEMREAD of 0x0040 returns the previously written value.
